// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client SDRAM burst arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Client indices: 0 = data cache, 1 = instruction cache
  localparam logic CLIENT_DC = 1'b0;
  localparam logic CLIENT_IC = 1'b1;

  localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Arbitration decision between the two clients.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- ties go to the client not
// granted last; otherwise the data cache (C0) always wins ties.
module mem_arb_select
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

`ifdef ARB_ROUND_ROBIN_EN
  // Tie favours the client that did not win last; single request wins outright
  always_comb begin
    grant = CLIENT_DC;
    if (&req)       grant = ~last_grant;
    else if (req[1]) grant = CLIENT_IC;
  end
`else
  // Fixed priority: C0 beats C1; history is not needed
  logic unused_last;
  assign unused_last = last_grant;
  assign grant = req[0] ? CLIENT_DC : (req[1] ? CLIENT_IC : CLIENT_DC);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-client burst arbiter in front of an SDRAM controller.
// Data paths are combinational pass-throughs gated by the current grant;
// request, address, direction, done and error are registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see mem_arb_select).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  // client 0 (data cache)
  input  logic                  i_C0_Req_Valid,
  input  logic                  i_C0_Read_Write_n,
  input  logic [ADDR_WIDTH-1:0] i_C0_Addr,
  input  logic [31:0]           i_C0_Data,
  output logic                  o_C0_Data_Read,
  output logic [31:0]           o_C0_Data,
  output logic                  o_C0_Data_Valid,
  output logic                  o_C0_Last,
  output logic                  o_C0_Done,
  // client 1 (instruction cache)
  input  logic                  i_C1_Req_Valid,
  input  logic                  i_C1_Read_Write_n,
  input  logic [ADDR_WIDTH-1:0] i_C1_Addr,
  input  logic [31:0]           i_C1_Data,
  output logic                  o_C1_Data_Read,
  output logic [31:0]           o_C1_Data,
  output logic                  o_C1_Data_Valid,
  output logic                  o_C1_Last,
  output logic                  o_C1_Done,
  // SDRAM controller
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic                  o_Mem_Read_Write_n,
  output logic                  o_Mem_Req_Valid,
  output logic [31:0]           o_Mem_Data,
  input  logic                  i_Mem_Data_Read,
  input  logic                  i_Mem_Data_Valid,
  input  logic                  i_Mem_Last,
  input  logic [31:0]           i_Mem_Data,
  output logic                  o_Proto_Err
);

  // Counter value expected on the final word of a correct burst
  localparam logic [1:0] LAST_IDX = 2'(BURST_LEN - 1);

  state_t                  state;
  logic                    grant;
  logic                    rr_last;   // history for tie break; resets to C1 so the first tie goes to C0
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    rw;
  logic                    req_valid;
  logic [1:0]              cnt;
  logic                    proto_err;
  logic [1:0]              done;
  logic [1:0]              req;
  logic                    sel;
  logic                    busy;
  logic                    hs;
  logic                    g0;
  logic                    g1;

  assign req  = {i_C1_Req_Valid, i_C0_Req_Valid};
  assign busy = (state == ST_BUSY);
  // A beat completes on read data arrival or on write data consumption
  assign hs   = busy & (rw ? i_Mem_Data_Valid : i_Mem_Data_Read);
  assign g0   = busy & (grant == CLIENT_DC);
  assign g1   = busy & (grant == CLIENT_IC);

  mem_arb_select u_sel (
    .req        (req),
    .last_grant (rr_last),
    .grant      (sel)
  );

  // Burst FSM: grant and latch in IDLE, count beats in BUSY, pulse done in DONE
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= ST_IDLE;
      grant     <= CLIENT_DC;
      rr_last   <= CLIENT_IC;
      addr      <= '0;
      rw        <= 1'b0;
      req_valid <= 1'b0;
      cnt       <= 2'd0;
      proto_err <= 1'b0;
      done      <= 2'b00;
    end else begin
      done <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= sel;
            rr_last   <= sel;
            addr      <= sel ? i_C1_Addr : i_C0_Addr;
            rw        <= sel ? i_C1_Read_Write_n : i_C0_Read_Write_n;
            req_valid <= 1'b1;
            cnt       <= 2'd0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (hs) begin
            cnt <= cnt + 2'd1;
            if (i_Mem_Last) begin
              // Early or late Last is flagged but the burst still closes
              if (cnt != LAST_IDX) proto_err <= 1'b1;
              req_valid   <= 1'b0;
              done[grant] <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          cnt   <= 2'd0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_Mem_Addr         = addr;
  assign o_Mem_Read_Write_n = rw;
  assign o_Mem_Req_Valid    = req_valid;
  assign o_Mem_Data         = grant ? i_C1_Data : i_C0_Data;
  assign o_Proto_Err        = proto_err;

  assign o_C0_Data       = i_Mem_Data;
  assign o_C1_Data       = i_Mem_Data;
  assign o_C0_Data_Read  = i_Mem_Data_Read  & g0;
  assign o_C1_Data_Read  = i_Mem_Data_Read  & g1;
  assign o_C0_Data_Valid = i_Mem_Data_Valid & g0;
  assign o_C1_Data_Valid = i_Mem_Data_Valid & g1;
  assign o_C0_Last       = i_Mem_Last       & g0;
  assign o_C1_Last       = i_Mem_Last       & g1;
  assign o_C0_Done       = done[0];
  assign o_C1_Done       = done[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;

  localparam logic [1:0] K_GNT = 2'd0, K_RD = 2'd1, K_WR = 2'd2, K_DN = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        cl;
    logic [31:0] data;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c0_req = 0, c0_rw = 0, c1_req = 0, c1_rw = 0;
  logic [21:0] c0_addr = '0, c1_addr = '0;
  logic [31:0] c0_data = '0, c1_data = '0;
  logic        mem_dr = 0, mem_dv = 0, mem_last = 0;
  logic [31:0] mem_data = '0;

  logic        o_C0_Data_Read, o_C0_Data_Valid, o_C0_Last, o_C0_Done;
  logic        o_C1_Data_Read, o_C1_Data_Valid, o_C1_Last, o_C1_Done;
  logic [31:0] o_C0_Data, o_C1_Data, o_Mem_Data;
  logic [21:0] o_Mem_Addr;
  logic        o_Mem_Read_Write_n, o_Mem_Req_Valid, o_Proto_Err;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  logic prev_rv = 1'b0;

  mem_arbiter dut (
    .i_Clk(clk), .i_Reset_n(rst_n),
    .i_C0_Req_Valid(c0_req), .i_C0_Read_Write_n(c0_rw), .i_C0_Addr(c0_addr), .i_C0_Data(c0_data),
    .o_C0_Data_Read(o_C0_Data_Read), .o_C0_Data(o_C0_Data), .o_C0_Data_Valid(o_C0_Data_Valid),
    .o_C0_Last(o_C0_Last), .o_C0_Done(o_C0_Done),
    .i_C1_Req_Valid(c1_req), .i_C1_Read_Write_n(c1_rw), .i_C1_Addr(c1_addr), .i_C1_Data(c1_data),
    .o_C1_Data_Read(o_C1_Data_Read), .o_C1_Data(o_C1_Data), .o_C1_Data_Valid(o_C1_Data_Valid),
    .o_C1_Last(o_C1_Last), .o_C1_Done(o_C1_Done),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_Read_Write_n(o_Mem_Read_Write_n), .o_Mem_Req_Valid(o_Mem_Req_Valid),
    .o_Mem_Data(o_Mem_Data), .i_Mem_Data_Read(mem_dr), .i_Mem_Data_Valid(mem_dv),
    .i_Mem_Last(mem_last), .i_Mem_Data(mem_data), .o_Proto_Err(o_Proto_Err)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(input logic [1:0] k, input logic c, input logic [31:0] d, input logic l);
    ev_t e;
    e.kind = k; e.cl = c; e.data = d; e.last = l;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic got(input ev_t a);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event got=%h", a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL event got=%h exp=%h", a, e);
      end
    end
  endtask

  // Monitor: every DUT strobe becomes an event compared against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_Mem_Req_Valid && !prev_rv) got(mk(K_GNT, 1'b0, 32'(o_Mem_Addr), o_Mem_Read_Write_n));
      if (o_C0_Data_Valid) got(mk(K_RD, 1'b0, o_C0_Data, o_C0_Last));
      if (o_C1_Data_Valid) got(mk(K_RD, 1'b1, o_C1_Data, o_C1_Last));
      if (o_C0_Data_Read)  got(mk(K_WR, 1'b0, o_Mem_Data, o_C0_Last));
      if (o_C1_Data_Read)  got(mk(K_WR, 1'b1, o_Mem_Data, o_C1_Last));
      if (o_C0_Done)       got(mk(K_DN, 1'b0, 32'd0, 1'b0));
      if (o_C1_Done)       got(mk(K_DN, 1'b1, 32'd0, 1'b0));
    end
    prev_rv <= o_Mem_Req_Valid;
  end

  // One burst by client win; Last on word nwords-1; abort>=0 resets after that word
  task automatic run_burst(input bit win, input bit rd, input logic [21:0] addr, input int nwords,
                           input bit gap, input int abort, input bit both);
    int          lat;
    logic [31:0] w;
    logic [21:0] oaddr;
    oaddr = addr ^ 22'h3F000;
    if (win) begin
      c1_req = 1; c1_rw = rd; c1_addr = addr;
      if (both) begin c0_req = 1; c0_rw = rd; c0_addr = oaddr; end
    end else begin
      c0_req = 1; c0_rw = rd; c0_addr = addr;
      if (both) begin c1_req = 1; c1_rw = rd; c1_addr = oaddr; end
    end
    exp_q.push_back(mk(K_GNT, 1'b0, 32'(addr), rd));
    lat = 0;
    while (!o_Mem_Req_Valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("grant_lat", lat, 1);
    if (!o_Mem_Req_Valid) begin c0_req = 0; c1_req = 0; return; end
    for (int i = 0; i < nwords; i++) begin
      w = {(rd ? 8'hA5 : 8'h5A), 2'b00, addr} + 32'(i);
      if (rd) begin
        mem_dv = 1; mem_data = w;
      end else begin
        mem_dr = 1;
        if (win) begin c1_data = w; c0_data = ~w; end
        else     begin c0_data = w; c1_data = ~w; end
      end
      mem_last = (i == nwords - 1);
      exp_q.push_back(mk(rd ? K_RD : K_WR, win, w, mem_last));
      if (!rd) begin #1; check("mem_wdata", o_Mem_Data, w); end
      @(posedge clk); #1;
      mem_dv = 0; mem_dr = 0; mem_last = 0;
      if (i == abort) begin
        mem_dv = 1; mem_dr = 1;
        rst_n = 0; #1;
        check("abort_req_valid", o_Mem_Req_Valid, 0);
        check("abort_strobes", {o_C0_Data_Valid, o_C1_Data_Valid, o_C0_Data_Read, o_C1_Data_Read}, 0);
        check("abort_done", {o_C0_Done, o_C1_Done}, 0);
        check("abort_addr", o_Mem_Addr, 0);
        check("abort_err", o_Proto_Err, 0);
        c0_req = 0; c1_req = 0;
        return;
      end
      if (i == nwords - 1) check("req_drop", o_Mem_Req_Valid, 0);
      else if (gap) begin @(posedge clk); #1; end
    end
    exp_q.push_back(mk(K_DN, win, 32'd0, 1'b0));
    c0_req = 0; c1_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit rr;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", o_Mem_Req_Valid, 0);
    check("rst_err", o_Proto_Err, 0);
    check("rst_addr", o_Mem_Addr, 0);
    check("rst_done", {o_C0_Done, o_C1_Done}, 0);
    rst_n = 1;

    // C1 read, then C0 write at top address, then gapped variants
    run_burst(1'b1, 1'b1, 22'h00123, 4, 1'b0, -1, 1'b0);
    check("err_after_read", o_Proto_Err, 0);
    run_burst(1'b0, 1'b0, 22'h3FFFFF, 4, 1'b0, -1, 1'b0);
    run_burst(1'b1, 1'b0, 22'h00456, 4, 1'b1, -1, 1'b0);
    run_burst(1'b0, 1'b1, 22'h2AAAA, 4, 1'b1, -1, 1'b0);
    check("err_clean", o_Proto_Err, 0);

    // Short burst: Last on 2nd word sets sticky error, FSM still completes
    run_burst(1'b0, 1'b1, 22'h00010, 2, 1'b0, -1, 1'b0);
    check("err_set", o_Proto_Err, 1);
    run_burst(1'b1, 1'b1, 22'h00020, 4, 1'b0, -1, 1'b0);
    check("err_sticky", o_Proto_Err, 1);

    // Reset after 2nd read word: no Done, clean restart
    run_burst(1'b1, 1'b1, 22'h00030, 4, 1'b0, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mem_dv = 0; mem_dr = 0;
    rst_n = 1;
    run_burst(1'b0, 1'b1, 22'h00040, 4, 1'b0, -1, 1'b0);

    // Two ties after a fresh reset
    rst_n = 0; #1;
    @(posedge clk); #1;
    rst_n = 1;
    run_burst(1'b0, 1'b1, 22'h00100, 4, 1'b0, -1, 1'b1);
    if (rr) run_burst(1'b1, 1'b1, 22'h00201, 4, 1'b0, -1, 1'b1);
    else    run_burst(1'b0, 1'b1, 22'h00101, 4, 1'b0, -1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
